// File: rtl/game_sequencer.sv
// game_sequencer: top-level game flow controller.
// It moves the game through title, roaming, battle intro, battle, post-battle
// and end screens, and tracks which elite battle is current.
module game_sequencer #(
  parameter int          NUM_BATTLES  = 5,
  parameter int          INTRO_FRAMES = 30,
  parameter logic [7:0]  ENTER_KEY    = 8'h28
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       start_battle,
  input  logic       new_room,
  input  logic       battle_won,
  input  logic       battle_lost,
  output logic       is_start,
  output logic       is_roam,
  output logic       is_battle,
  output logic [2:0] cur_battle,
  output logic       battle_begin,
  output logic       intro_active,
  output logic [7:0] intro_count,
  output logic       game_won,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_TITLE,
    S_ROAM,
    S_INTRO,
    S_BATTLE,
    S_POST,
    S_WIN,
    S_LOSE
  } state_t;

  localparam logic [2:0] LAST_BATTLE = 3'(NUM_BATTLES - 1);
  localparam logic [7:0] INTRO_LAST  = 8'(INTRO_FRAMES);

  state_t     state;
  state_t     state_next;
  logic [2:0] cur_battle_next;
  logic [7:0] intro_count_next;
  logic       frame_q;
  logic       frame_qq;
  logic       enter_q;
  logic       fe;
  logic       ce;

  // Sample frame_clk and the confirm key so rising edges / fresh presses can be detected.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q  <= 1'b0;
      frame_qq <= 1'b0;
      enter_q  <= 1'b0;
    end else begin
      frame_q  <= frame_clk;
      frame_qq <= frame_q;
      enter_q  <= (keycode == ENTER_KEY);
    end
  end

  assign fe = frame_q & ~frame_qq;
  assign ce = (keycode == ENTER_KEY) & ~enter_q;

  // State register plus the battle index, intro counter and battle-entry pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= S_TITLE;
      cur_battle   <= 3'd0;
      intro_count  <= 8'd0;
      battle_begin <= 1'b0;
    end else begin
      state        <= state_next;
      cur_battle   <= cur_battle_next;
      intro_count  <= intro_count_next;
      battle_begin <= (state == S_INTRO) && (state_next == S_BATTLE);
    end
  end

  // Next-state and next-counter logic; pulses not relevant to a state are ignored.
  always_comb begin
    state_next       = state;
    cur_battle_next  = cur_battle;
    intro_count_next = intro_count;
    case (state)
      S_TITLE: begin
        if (ce) begin
          state_next      = S_ROAM;
          cur_battle_next = 3'd0;
        end
      end
      S_ROAM: begin
        if (start_battle) begin
          state_next       = S_INTRO;
          intro_count_next = 8'd0;
        end
      end
      S_INTRO: begin
        if (fe) begin
          intro_count_next = intro_count + 8'd1;
          if (intro_count + 8'd1 == INTRO_LAST) begin
            state_next = S_BATTLE;
          end
        end
      end
      S_BATTLE: begin
        if (battle_lost) begin
          state_next = S_LOSE;
        end else if (battle_won) begin
          state_next = (cur_battle == LAST_BATTLE) ? S_WIN : S_POST;
        end
      end
      S_POST: begin
        if (new_room) begin
          state_next = S_ROAM;
          if (cur_battle != LAST_BATTLE) begin
            cur_battle_next = cur_battle + 3'd1;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (ce) begin
          state_next      = S_TITLE;
          cur_battle_next = 3'd0;
        end
      end
      default: begin
        state_next = S_TITLE;
      end
    endcase
  end

  // Moore output decode from the registered state; exactly one flag is high.
  always_comb begin
    is_start     = 1'b0;
    is_roam      = 1'b0;
    is_battle    = 1'b0;
    intro_active = 1'b0;
    game_won     = 1'b0;
    game_over    = 1'b0;
    case (state)
      S_TITLE:        is_start     = 1'b1;
      S_ROAM, S_POST: is_roam      = 1'b1;
      S_INTRO:        intro_active = 1'b1;
      S_BATTLE:       is_battle    = 1'b1;
      S_WIN:          game_won     = 1'b1;
      S_LOSE:         game_over    = 1'b1;
      default:        is_start     = 1'b1;
    endcase
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter NUM_BATTLES, default 5, number of elite battles in the run (1-8).
REQ-002 SHALL have parameter INTRO_FRAMES, default 30, frame_clk rising edges spent in the battle-intro transition (1-255).
REQ-003 SHALL have parameter ENTER_KEY, default 8'h28, keycode that confirms on title and end screens.
REQ-004 Clk  in  1  system clock.
REQ-005 Reset  in  1  reset; synchronous, active-high; clock Clk.
REQ-006 frame_clk  in  1  vertical-sync-rate tick, level signal sampled on Clk.
REQ-007 keycode  in  8  current keyboard keycode, 0 when no key is pressed.
REQ-008 start_battle  in  1  one-Clk pulse from the roam block requesting a battle.
REQ-009 new_room  in  1  one-Clk pulse from the roam block: the player has exited to the next room.
REQ-010 battle_won  in  1  one-Clk pulse from the battle engine.
REQ-011 battle_lost  in  1  one-Clk pulse from the battle engine.
REQ-012 is_start  out  1  title screen active; feeds the roam block's position reset.
REQ-013 is_roam  out  1  overworld roaming enabled.
REQ-014 is_battle  out  1  battle engine active.
REQ-015 cur_battle  out  3  index of the current or next elite (0..NUM_BATTLES-1).
REQ-016 battle_begin  out  1  one-Clk pulse on entry to BATTLE.
REQ-017 intro_active  out  1  battle-intro transition is running.
REQ-018 intro_count  out  8  frame edges elapsed in the intro, for the fade effect.
REQ-019 game_won / game_over  out  1 each  end-screen selectors.

Function
REQ-020 SHALL detect the frame tick as a one-Clk pulse fe, asserted in the cycle after frame_clk is sampled 1 and was sampled 0 in the previous cycle.
REQ-021 SHALL detect a confirm press ce as keycode==ENTER_KEY this cycle and keycode!=ENTER_KEY last cycle; a held key SHALL produce exactly one ce.
REQ-022 States SHALL be TITLE, ROAM, INTRO, BATTLE, POST, WIN, LOSE; outputs SHALL decode from registered state (Moore), except battle_begin.
REQ-023 TITLE: is_start=1; on ce -> ROAM and cur_battle<=0.
REQ-024 ROAM: is_roam=1; on start_battle -> INTRO and intro_count<=0; new_room SHALL be ignored.
REQ-025 INTRO: intro_active=1; each fe SHALL increment intro_count; on the fe that makes intro_count equal INTRO_FRAMES -> BATTLE.
REQ-026 battle_begin SHALL be 1 for exactly the first Clk cycle in which state==BATTLE.
REQ-027 BATTLE: is_battle=1; battle_lost -> LOSE; else battle_won -> WIN if cur_battle==NUM_BATTLES-1, otherwise POST; simultaneous won and lost SHALL resolve as lost.
REQ-028 POST: is_roam=1 so the player walks to the exit; on new_room -> ROAM and cur_battle<=cur_battle+1; start_battle SHALL be ignored.
REQ-029 cur_battle SHALL never exceed NUM_BATTLES-1 and SHALL not wrap.
REQ-030 WIN: game_won=1; LOSE: game_over=1; on ce either SHALL -> TITLE and cur_battle<=0.
REQ-031 Pulse inputs arriving in any state not listed for them SHALL have no effect.
REQ-032 Exactly one of is_start, is_roam, is_battle, intro_active, game_won, game_over SHALL be 1 in every cycle.

Reset
REQ-033 While Reset=1 at a Clk edge: state<=TITLE, cur_battle<=0, intro_count<=0, edge-detect history registers <=0; battle_begin SHALL be 0.
REQ-034 Reset SHALL take priority over all inputs in every state, including mid-INTRO and mid-BATTLE.
REQ-035 After reset, is_start=1 and all other outputs SHALL be 0.

Verification
REQ-036 Reset; keycode=8'h28 held 10 cycles -> single transition TITLE->ROAM, is_roam=1, cur_battle=0.
REQ-037 ROAM, start_battle pulse, INTRO_FRAMES=30 -> intro_active for exactly 30 frame edges, then is_battle=1 and battle_begin high for 1 cycle.
REQ-038 BATTLE cur_battle=2, battle_won -> POST; start_battle ignored; new_room -> ROAM with cur_battle=3.
REQ-039 BATTLE cur_battle=4, battle_won -> WIN, game_won=1; ENTER press -> TITLE, cur_battle=0.
REQ-040 BATTLE, battle_won and battle_lost in same cycle -> LOSE, game_over=1, cur_battle unchanged.
REQ-041 Reset asserted mid-INTRO at intro_count=12 -> next cycle TITLE, intro_count=0, is_start=1.
